// File: rtl/reg_file_dumper.sv
// Walks a range of register-file indices through one read port and streams {index, value} words out.
// Optional checksum output enabled with the REG_DUMP_CHECKSUM_EN macro.
module reg_file_dumper #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    // Handshake: a word transfers on a rising edge where out_valid and out_ready are both high;
    // out_reg/out_data are held stable while out_valid is high and out_ready is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last;
    logic              xfer;

    assign xfer = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = READ;
            READ: next_state = SEND;
            SEND: if (out_ready) next_state = (cur == last) ? DONE : READ;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rf_read_reg = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            READ: begin
                rf_read_reg = cur;
                busy        = 1'b1;
            end
            SEND: busy = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Index counter wraps naturally at 2^ADDR_W, giving the wrapping range behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
            out_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                cur  <= first_reg;
                last <= last_reg;
            end
            if (state == READ) begin
                out_data  <= rf_read_data;
                out_reg   <= cur;
                out_valid <= 1'b1;
            end
            if (xfer) begin
                out_valid <= 1'b0;
                if (cur != last) cur <= cur + 1'b1;
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_dumper.sv
// Randomized bench for reg_file_dumper: a transaction-level model predicts every output each cycle.
// Build with REG_DUMP_CHECKSUM_EN defined to also check the checksum output.
module tb_reg_file_dumper;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_reg = '0;
    logic [AW-1:0] last_reg = '0;
    logic [AW-1:0] rf_read_reg;
    logic [DW-1:0] rf_read_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_reg;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] regs [32];
    assign rf_read_data = regs[rf_read_reg];

    reg_file_dumper #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_reg(first_reg), .last_reg(last_reg),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg(out_reg), .out_data(out_data),
        .busy(busy), .done(done)
`ifdef REG_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: remaining indices of the current dump, plus the word on offer.
    logic [AW-1:0] exp_q[$];
    bit            m_busy, m_valid, m_done;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data, m_sum;
    int            cyc, start_cyc, done_cyc, xfers;
    logic [AW-1:0] last_xfer_reg;
    logic [DW-1:0] last_xfer_data;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_valid = 0; m_done = 0;
                m_reg = '0; m_data = '0; m_sum = '0;
                exp_q.delete();
            end else begin
                cyc++;
                if (m_done) begin
                    m_done = 0;
                end else if (!m_busy) begin
                    if (start) begin
                        int n;
                        n = ((int'(last_reg) - int'(first_reg) + 32) % 32) + 1;
                        for (int k = 0; k < n; k++) exp_q.push_back(AW'((int'(first_reg) + k) % 32));
                        m_busy = 1; m_sum = '0; start_cyc = cyc; xfers = 0;
                    end
                end else if (!m_valid) begin
                    m_reg   = exp_q.pop_front();
                    m_data  = regs[m_reg];
                    m_valid = 1;
                end else if (out_ready) begin
                    m_sum ^= m_data;
                    m_valid = 0;
                    xfers++;
                    last_xfer_reg  = m_reg;
                    last_xfer_data = m_data;
                    if (exp_q.size() == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle out of reset, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid", 64'(out_valid), 64'(m_valid));
                check("busy", 64'(busy), 64'(m_busy && !m_done));
                check("done", 64'(done), 64'(m_done));
                check("rf_read_reg", 64'(rf_read_reg),
                      (m_busy && !m_valid && exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
                if (m_valid) begin
                    check("out_reg", 64'(out_reg), 64'(m_reg));
                    check("out_data", 64'(out_data), 64'(m_data));
                end
                if (done && out_valid) check("done_and_valid", 64'd1, 64'd0);
`ifdef REG_DUMP_CHECKSUM_EN
                check("checksum", 64'(checksum), 64'(m_sum));
`endif
                if (done) done_cyc = cyc;
            end
        end
    end

    bit rand_writes = 0;

    // mode 0: ready always high, 1: random ready, 2: ready low for the first 4 cycles of word 1.
    task automatic do_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                           input bit inj_start, input bit inj_rst);
        int  guard, stall;
        bit  fin;
        guard = 0; stall = 0; fin = 0;
        while ((busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        start = 1; first_reg = f; last_reg = l;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 0;
        first_reg = AW'($urandom_range(0, 31));
        last_reg  = AW'($urandom_range(0, 31));
        guard = 0;
        while (!fin && guard < 400) begin
            if (done) begin
                fin = 1;
            end else begin
                if (rand_writes && $urandom_range(0, 2) == 0)
                    regs[$urandom_range(0, 31)] = $urandom;
                case (mode)
                    1: out_ready = 1'($urandom_range(0, 1));
                    2: begin
                        out_ready = 1'b1;
                        if (out_valid && stall < 4) begin
                            out_ready = 1'b0;
                            stall++;
                        end
                    end
                    default: out_ready = 1'b1;
                endcase
                start = (inj_start && guard == 2);
                if (start) begin
                    first_reg = 5'd10;
                    last_reg  = 5'd12;
                end
                if (inj_rst && out_valid && out_reg == AW'(f + 1'b1)) begin
                    rst_n = 0;
                    #1;
                    check("rst_out_valid", 64'(out_valid), 64'd0);
                    check("rst_busy", 64'(busy), 64'd0);
                    check("rst_done", 64'(done), 64'd0);
                    check("rst_out_data", 64'(out_data), 64'd0);
                    repeat (2) @(negedge clk);
                    rst_n = 1;
                    fin = 1;
                end
                if (!fin) begin
                    @(negedge clk);
                    guard++;
                end
            end
        end
        start = 0;
        if (!fin) check("dump_timeout", 64'(guard), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_out_reg", 64'(out_reg), 64'd0);
        check("reset_rf_read_reg", 64'(rf_read_reg), 64'd0);
        rst_n = 1;
        @(negedge clk);

        // Single word: done is seen 2N edges after the start edge (cycle 2N+1 counting from 1).
        regs[5] = 32'h0000_00AA;
        do_dump(5'd5, 5'd5, 0, 0, 0);
        check("single_xfers", 64'(xfers), 64'd1);
        check("single_reg", 64'(last_xfer_reg), 64'd5);
        check("single_data", 64'(last_xfer_data), 64'h0000_00AA);
        check("single_latency", 64'(done_cyc - start_cyc), 64'd2);

        for (int i = 0; i < 32; i++) regs[i] = DW'(i * 32'h11);
        do_dump(5'd3, 5'd2, 0, 0, 0);
        check("wrap_xfers", 64'(xfers), 64'd32);
        check("wrap_last_reg", 64'(last_xfer_reg), 64'd2);
        check("wrap_last_data", 64'(last_xfer_data), 64'h22);
        check("wrap_latency", 64'(done_cyc - start_cyc), 64'd64);

        do_dump(5'd1, 5'd2, 2, 0, 0);
        check("stall_xfers", 64'(xfers), 64'd2);
        check("stall_latency", 64'(done_cyc - start_cyc), 64'd8);

        do_dump(5'd0, 5'd3, 0, 1, 0);
        check("busy_start_xfers", 64'(xfers), 64'd4);
        check("busy_start_last", 64'(last_xfer_reg), 64'd3);

        do_dump(5'd0, 5'd5, 0, 0, 1);
        do_dump(5'd7, 5'd9, 0, 0, 0);
        check("after_rst_xfers", 64'(xfers), 64'd3);
        check("after_rst_data", 64'(last_xfer_data), 64'h99);

        regs[0] = 32'h0;
        regs[1] = 32'h0000_FFFF;
        do_dump(5'd0, 5'd1, 0, 0, 0);
        check("sum_model", 64'(m_sum), 64'h0000_FFFF);
`ifdef REG_DUMP_CHECKSUM_EN
        check("sum_final", 64'(checksum), 64'h0000_FFFF);
        @(negedge clk);
        start = 1; first_reg = 5'd4; last_reg = 5'd4;
        @(negedge clk);
        start = 0;
        check("sum_cleared", 64'(checksum), 64'd0);
        repeat (4) @(negedge clk);
`endif

        rand_writes = 1;
        for (int t = 0; t < 20; t++)
            do_dump(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), 1, 1'($urandom_range(0, 1)), 0);
        rand_writes = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
